// File: rtl/rr_mux_arb_pkg.sv
// Shared types for the 4-requester round-robin AND-OR mux arbiter.
package rr_mux_arb_pkg;
  localparam int N_REQ = 4;

  typedef logic [1:0] req_idx_t;
  typedef logic [3:0] req_vec_t;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  function automatic req_vec_t idx_to_onehot(input req_idx_t idx);
    return req_vec_t'(4'b0001 << idx);
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first valid requester scanning ptr+1, ptr+2, ... ptr (mod 4).
module rr_priority_pick
  import rr_mux_arb_pkg::*;
(
  input  req_vec_t valid,
  input  req_idx_t ptr,
  output req_vec_t grant,
  output req_idx_t idx,
  output logic     any
);

  // Scan starts just after the last grant so the previous winner is considered last
  always_comb begin
    grant = 4'b0000;
    idx   = ptr;
    any   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!any && valid[req_idx_t'(int'(ptr) + k)]) begin
        any   = 1'b1;
        idx   = req_idx_t'(int'(ptr) + k);
        grant = idx_to_onehot(req_idx_t'(int'(ptr) + k));
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin 4:1 valid/ready arbiter with AND-OR data mux and one registered output stage.
// Optional packet lock (grant pinned until in_last) enabled by defining RR_ARB_LOCK_EN.
module rr_mux_arbiter_4
  import rr_mux_arb_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  output logic [3:0]          in_ready,
`ifdef RR_ARB_LOCK_EN
  input  logic [3:0]          in_last,
  output logic                out_last,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_src
);

  arb_state_t        state;
  req_idx_t          ptr;
  req_idx_t          lock_idx;
  logic              load;
  req_vec_t          pick_grant;
  req_idx_t          pick_idx;
  logic              pick_any;
  req_vec_t          grant;
  req_idx_t          win_idx;
  logic              win_any;
  logic              win_last;
  logic              hs;
  logic [DATA_W-1:0] mux_data;

  assign load = ~out_valid | out_ready;

  rr_priority_pick u_pick (
    .valid (in_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // In LOCK only the locked requester may win; otherwise the round-robin pick does
  always_comb begin
    grant   = 4'b0000;
    win_idx = pick_idx;
    win_any = 1'b0;
    case (state)
      ARB: begin
        grant   = pick_grant;
        win_idx = pick_idx;
        win_any = pick_any;
      end
      LOCK: begin
        win_idx = lock_idx;
        win_any = in_valid[lock_idx];
        grant   = in_valid[lock_idx] ? idx_to_onehot(lock_idx) : 4'b0000;
      end
      default: begin
        grant   = 4'b0000;
        win_idx = pick_idx;
        win_any = 1'b0;
      end
    endcase
  end

  assign in_ready = load ? grant : 4'b0000;
  assign hs       = load & win_any;

  // Gate-level AND-OR select driven directly by the one-hot grant
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mux_data = mux_data | (in_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
    end
  end

`ifdef RR_ARB_LOCK_EN
  assign win_last = in_last[win_idx];
`else
  // Without packet lock every beat is a complete packet, so the FSM never leaves ARB
  assign win_last = 1'b1;
`endif

  // Output stage, round-robin pointer and packet-lock FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      ptr       <= 2'd3;
      lock_idx  <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
`ifdef RR_ARB_LOCK_EN
      out_last  <= 1'b0;
`endif
    end else if (load) begin
      if (hs) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_src   <= win_idx;
        ptr       <= win_idx;
        lock_idx  <= win_idx;
`ifdef RR_ARB_LOCK_EN
        out_last  <= win_last;
`endif
        case (state)
          ARB:     state <= win_last ? ARB : LOCK;
          LOCK:    state <= win_last ? ARB : LOCK;
          default: state <= ARB;
        endcase
      end else begin
        out_valid <= 1'b0;
      end
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Randomized self-checking bench for rr_mux_arbiter_4 against a round-robin reference model.
// Packet-lock scenarios run only when RR_ARB_LOCK_EN is defined.
module tb_rr_mux_arbiter_4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_src;
`ifdef RR_ARB_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_ptr;
  bit m_valid;
  int m_data;
  int m_src;
  bit m_last;
  bit m_locked;
  int m_lock_idx;

  rr_mux_arbiter_4 #(.DATA_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef RR_ARB_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr      = 3;
    m_valid    = 1'b0;
    m_data     = 0;
    m_src      = 0;
    m_last     = 1'b0;
    m_locked   = 1'b0;
    m_lock_idx = 0;
  endfunction

  // -1 when nobody may win this cycle
  function automatic int model_winner();
    if (m_locked) return in_valid[m_lock_idx] ? m_lock_idx : -1;
    for (int k = 1; k <= 4; k++) begin
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  // inputs are already driven (just after a negedge); check ready, clock once, check outputs
  task automatic cycle();
    int         w;
    bit         ld;
    bit         lst;
    logic [3:0] exp_rdy;
    #1;
    ld      = !m_valid || out_ready;
    w       = model_winner();
    exp_rdy = (ld && w >= 0) ? (4'b0001 << w) : 4'b0000;
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (ld) begin
      if (w >= 0) begin
        lst = 1'b1;
`ifdef RR_ARB_LOCK_EN
        lst = in_last[w];
`endif
        m_valid = 1'b1;
        m_data  = int'(in_data[w*4 +: 4]);
        m_src   = w;
        m_ptr   = w;
        m_last  = lst;
        if (!m_locked && !lst) begin
          m_locked   = 1'b1;
          m_lock_idx = w;
        end else if (m_locked && lst) begin
          m_locked = 1'b0;
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("out_data", 32'(out_data), 32'(m_data));
    check_eq("out_src", 32'(out_src), 32'(m_src));
`ifdef RR_ARB_LOCK_EN
    check_eq("out_last", 32'(out_last), 32'(m_last));
`endif
  endtask

  // asynchronous reset pulse, called just after a negedge
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int saved_src;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    in_data   = 16'h0000;
    out_ready = 1'b1;
`ifdef RR_ARB_LOCK_EN
    in_last   = 4'b1111;
`endif
    model_reset();
    #2;
    check_eq("rst_out_valid", 32'(out_valid), 32'(0));
    check_eq("rst_out_data", 32'(out_data), 32'(0));
    check_eq("rst_out_src", 32'(out_src), 32'(0));
    check_eq("rst_in_ready", 32'(in_ready), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // idle, then a lone request from requester 0
    cycle();
    cycle();
    in_valid = 4'b0001;
    in_data  = 16'h0005;
    cycle();
    check_eq("first_req_src", 32'(out_src), 32'(0));
    check_eq("first_req_valid", 32'(out_valid), 32'(1));

    // full rotation from reset
    apply_reset();
    in_valid = 4'b1111;
    in_data  = {4'hD, 4'hC, 4'hB, 4'hA};
    for (int k = 0; k < 8; k++) begin
      cycle();
      check_eq("rr_src", 32'(out_src), 32'(k % 4));
      check_eq("rr_data", 32'(out_data), 32'(10 + k % 4));
    end

    // backpressure for 3 cycles, then rotation resumes after the held source
    saved_src = int'(out_src);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("bp_src_stable", 32'(out_src), 32'(saved_src));
    end
    out_ready = 1'b1;
    cycle();
    check_eq("bp_resume_src", 32'(out_src), 32'((saved_src + 1) % 4));
    cycle();

    // a single continuous requester gets every cycle
    in_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_eq("solo_src", 32'(out_src), 32'(2));
      check_eq("solo_valid", 32'(out_valid), 32'(1));
    end

    // async reset mid-stream with out_valid high
    in_valid = 4'b1111;
    cycle();
    apply_reset();
    cycle();
    check_eq("post_rst_src", 32'(out_src), 32'(0));

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef RR_ARB_LOCK_EN
      in_last   = 4'($urandom_range(0, 15));
`endif
      cycle();
    end
    out_ready = 1'b1;

`ifdef RR_ARB_LOCK_EN
    // requester 1 sends a 3-beat packet while 0 and 2 compete
    apply_reset();
    in_last  = 4'b1111;
    in_valid = 4'b0001;
    cycle();
    in_valid = 4'b0111;
    in_last  = 4'b1101;
    cycle();
    check_eq("lock_src_b1", 32'(out_src), 32'(1));
    cycle();
    check_eq("lock_src_b2", 32'(out_src), 32'(1));
    in_last = 4'b1111;
    cycle();
    check_eq("lock_src_b3", 32'(out_src), 32'(1));
    cycle();
    check_eq("lock_src_next", 32'(out_src), 32'(2));

    // a gap in the locked requester gives a bubble, not a switch
    apply_reset();
    in_valid = 4'b0001;
    cycle();
    in_valid = 4'b0111;
    in_last  = 4'b1101;
    cycle();
    check_eq("gap_src_b1", 32'(out_src), 32'(1));
    in_valid = 4'b0101;
    cycle();
    check_eq("gap_bubble", 32'(out_valid), 32'(0));
    in_valid = 4'b0111;
    cycle();
    check_eq("gap_src_b2", 32'(out_src), 32'(1));
    in_last = 4'b1111;
    cycle();
    check_eq("gap_src_b3", 32'(out_src), 32'(1));
    cycle();
    check_eq("gap_src_next", 32'(out_src), 32'(2));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
